rs_latch_driver: RTL and testbench
==================================

# rs_latch_driver

Upstream conditioning stage for the NAND RS latch. Takes two raw, bouncing, asynchronous push-button inputs (set, reset), synchronises and debounces each, and converts each debounced press into a clean, fixed-width active-low pulse on the latch's set or reset input. It guarantees the latch never sees both inputs low together, which is the forbidden NAND-latch state. It also reports conflicting presses.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before a debounced level changes (≥2).
- PULSE_CYCLES, 2: cycles a generated pulse holds s_out or r_out low (≥1).
- GUARD_CYCLES, 1: cycles with both outputs high after every pulse (≥1).

Ports:
- clk_in  input  1  single system clock; all state changes on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- set_btn_in  input  1  raw set button, active-high, asynchronous, may bounce.
- reset_btn_in  input  1  raw reset button, active-high, asynchronous, may bounce.
- s_out  output  1  active-low set to latch s_in; registered.
- r_out  output  1  active-low reset to latch r_in; registered.
- busy_out  output  1  high while in PULSE_S, PULSE_R or GUARD.
- conflict_out  output  1  one-cycle high pulse when a set and a reset request collide.

## Operation
- Reset (asynchronous, immediate):
  - s_out=1, r_out=1 (latch holds its state).
  - busy_out=0, conflict_out=0.
  - Synchronisers, debounced levels, counters and pending flags all 0.
  - FSM goes to IDLE.
- Per input:
  - A two-flop synchroniser feeds a debounce counter.
  - While the synchronised value equals the debounced level, the counter is 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced level flips and the counter clears.
  - Any agreement before that point clears the counter, so bounces shorter than DEBOUNCE_CYCLES are ignored.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it does not wrap.
- A rising edge of a debounced level sets that input's pending flag. Falling edges (release) do nothing.
- FSM states are IDLE, PULSE_S, PULSE_R and GUARD:
  - IDLE, only set pending: go to PULSE_S and clear the set flag.
  - IDLE, only reset pending: go to PULSE_R and clear the reset flag.
  - IDLE, both pending (including simultaneous edges): clear both flags, pulse conflict_out for 1 cycle, stay in IDLE. No pulse is issued.
  - PULSE_S: s_out=0 for PULSE_CYCLES cycles, then go to GUARD.
  - PULSE_R: r_out=0 for PULSE_CYCLES cycles, then go to GUARD.
  - GUARD: both outputs high for GUARD_CYCLES cycles, then go to IDLE.
- Presses while busy are kept as pending flags (one deep each). Repeat presses of the same input while it is already pending merge into one.
- Invariant: s_out and r_out are never both 0.

## Timing
- Raw level first sampled at edge 0: synchronised after edge 1, debounced level flips at edge DEBOUNCE_CYCLES+1, FSM leaves IDLE at edge DEBOUNCE_CYCLES+2.
- s_out or r_out therefore falls at edge DEBOUNCE_CYCLES+2 (edge 18 by default) and rises PULSE_CYCLES edges later.
- Back-to-back pulses are separated by at least GUARD_CYCLES+1 cycles (GUARD plus one IDLE cycle).
- conflict_out asserts on the edge the FSM resolves the collision in IDLE.
- Reset asserted mid-pulse: outputs go high immediately; pending requests are lost.
- Reset deassertion: the first press needs the full debounce time; a button held through reset produces one press after DEBOUNCE_CYCLES+2 edges.

## Structure
- Package rs_drv_pkg holds:
  - state enum typedef (IDLE, PULSE_S, PULSE_R, GUARD);
  - default constants for the three parameters;
  - a counter-width function.
- Sub-module debounce_cell (synchroniser, counter, debounced-level register, rise-edge output) is instantiated twice.
- The FSM, pending flags and output registers live in the top level.

## Test plan
- Reset values: hold rst_n_in=0 → s_out=1, r_out=1, busy_out=0, conflict_out=0. Assert reset during PULSE_S → s_out goes to 1 without waiting for a clock.
- Clean set press, defaults: set_btn_in 0→1 sampled at edge 0 → s_out=0 for edges 18–19, high at 20, busy_out deasserts after the guard cycle; r_out stays 1 throughout.
- Bounce rejection: set_btn_in toggles every 5 cycles for 60 cycles, then returns to 0 → no pulse on s_out or r_out.
- Simultaneous press: both buttons rise on the same edge → conflict_out=1 for exactly 1 cycle, s_out and r_out stay 1.
- Queued request: reset pressed 4 cycles after set → set pulse first; r_out=0 starts 2 cycles after s_out returns high (1 guard + 1 IDLE); conflict_out stays 0.
- Randomised soak: random bouncing on both inputs for 10k cycles → assertion that s_out and r_out are never both 0, and every low pulse is exactly PULSE_CYCLES wide.

Source files
------------

// File: rtl/rs_latch_driver_pkg.sv
// rs_drv_pkg: shared definitions for the NAND RS latch driver.
//   - state_t        : driver FSM state encoding
//   - DEF_*          : default values of the driver parameters
//   - cnt_width()    : width of a counter that must hold 0..n-1 (min 1 bit)
package rs_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GUARD   = 2'd3
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;
    localparam int unsigned DEF_GUARD_CYCLES    = 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rs_latch_driver_if.sv
// rs_latch_driver_if: button inputs and latch-side outputs of the driver.
//   set_btn_in / reset_btn_in : raw active-high buttons (asynchronous, bouncing)
//   s_out / r_out             : active-low pulses to the latch s_in / r_in
//   busy_out                  : high while a pulse or guard interval is running
//   conflict_out              : one-cycle flag for a colliding set/reset request
// slave  : the driver side; master : the side that presses the buttons.
interface rs_latch_driver_if;

    logic set_btn_in;
    logic reset_btn_in;
    logic s_out;
    logic r_out;
    logic busy_out;
    logic conflict_out;

    modport slave (
        input  set_btn_in,
        input  reset_btn_in,
        output s_out,
        output r_out,
        output busy_out,
        output conflict_out
    );

    modport master (
        output set_btn_in,
        output reset_btn_in,
        input  s_out,
        input  r_out,
        input  busy_out,
        input  conflict_out
    );

endinterface

// File: rtl/rs_latch_driver_debounce.sv
// debounce_cell: two-flop synchroniser plus stability counter for one button.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_raw   : raw asynchronous button level
//   o_rise  : one-cycle high, combinational, in the cycle whose rising edge
//             flips the debounced level from 0 to 1
module debounce_cell
    import rs_drv_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    // Flip once the disagreement has been seen DEBOUNCE_CYCLES times in a row.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign o_rise = w_flip && !r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= !r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: debounces two raw buttons and turns each press into a
// fixed-width active-low pulse on the NAND latch set or reset input, never
// driving both low together.
//   clk_in   : system clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : rs_latch_driver_if.slave (buttons in, latch pulses/status out)
module rs_latch_driver
    import rs_drv_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned GUARD_CYCLES    = DEF_GUARD_CYCLES
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    rs_latch_driver_if.slave bus
);

    localparam int unsigned PMAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int unsigned PW   = cnt_width(PMAX);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_phase;
    logic          r_pend_s;
    logic          r_pend_r;
    logic          r_s_out;
    logic          r_r_out;
    logic          r_busy;
    logic          r_conflict;

    logic          w_rise_s;
    logic          w_rise_r;
    logic          w_take_s;
    logic          w_take_r;
    logic          w_conflict;
    logic          w_s_next;
    logic          w_r_next;
    logic          w_busy_next;

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_set (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_raw   (bus.set_btn_in),
        .o_rise  (w_rise_s)
    );

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_reset (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_raw   (bus.reset_btn_in),
        .o_rise  (w_rise_r)
    );

    // State, phase counter, pending flags and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_pend_s   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_s_out    <= 1'b1;
            r_r_out    <= 1'b1;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Phase counts cycles spent in the current pulse/guard state.
            if ((w_state_next != r_state) || (r_state == IDLE)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
            // A fresh rise wins over a consume in the same cycle so no press is lost.
            r_pend_s   <= w_rise_s || (r_pend_s && !w_take_s);
            r_pend_r   <= w_rise_r || (r_pend_r && !w_take_r);
            r_s_out    <= w_s_next;
            r_r_out    <= w_r_next;
            r_busy     <= w_busy_next;
            r_conflict <= w_conflict;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_take_s     = 1'b0;
        w_take_r     = 1'b0;
        w_conflict   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pend_s && r_pend_r) begin
                    w_take_s   = 1'b1;
                    w_take_r   = 1'b1;
                    w_conflict = 1'b1;
                end else if (r_pend_s) begin
                    w_take_s     = 1'b1;
                    w_state_next = PULSE_S;
                end else if (r_pend_r) begin
                    w_take_r     = 1'b1;
                    w_state_next = PULSE_R;
                end
            end
            PULSE_S: begin
                if (r_phase == PW'(PULSE_CYCLES - 1)) w_state_next = GUARD;
            end
            PULSE_R: begin
                if (r_phase == PW'(PULSE_CYCLES - 1)) w_state_next = GUARD;
            end
            GUARD: begin
                if (r_phase == PW'(GUARD_CYCLES - 1)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register alongside it;
    // s and r can only go low in mutually exclusive states.
    always_comb begin
        w_s_next    = (w_state_next != PULSE_S);
        w_r_next    = (w_state_next != PULSE_R);
        w_busy_next = (w_state_next != IDLE);
    end

    assign bus.s_out        = r_s_out;
    assign bus.r_out        = r_r_out;
    assign bus.busy_out     = r_busy;
    assign bus.conflict_out = r_conflict;

endmodule

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver: directed bench for rs_latch_driver with default timing
// (debounce 16, pulse 2, guard 1). "Edge 0" is the first rising edge that
// samples a new raw button level; checks are taken 1 time unit after edges.
module tb_rs_latch_driver;

    localparam int unsigned DB = 16;
    localparam int unsigned PC = 2;
    localparam int unsigned GC = 1;

    logic clk_in;
    logic rst_n_in;
    int   checks;
    int   errors;
    int   s_w;
    int   r_w;

    rs_latch_driver_if bus ();

    rs_latch_driver #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PC),
        .GUARD_CYCLES   (GC)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = !clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int unsigned n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic r,
                              input logic busy, input logic conf);
        check({tag, ".s_out"}, bus.s_out, s);
        check({tag, ".r_out"}, bus.r_out, r);
        check({tag, ".busy"}, bus.busy_out, busy);
        check({tag, ".conflict"}, bus.conflict_out, conf);
    endtask

    // Invariant and pulse-width watch, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            s_w = 0;
            r_w = 0;
        end else begin
            check("both_low", (bus.s_out === 1'b0) && (bus.r_out === 1'b0), 1'b0);
            if (bus.s_out === 1'b0) begin
                s_w++;
            end else if (s_w != 0) begin
                check("s_width", s_w, PC);
                s_w = 0;
            end
            if (bus.r_out === 1'b0) begin
                r_w++;
            end else if (r_w != 0) begin
                check("r_width", r_w, PC);
                r_w = 0;
            end
        end
    end

    initial begin
        logic glitch;
        checks = 0;
        errors = 0;
        s_w = 0;
        r_w = 0;
        rst_n_in = 1'b0;
        bus.set_btn_in = 1'b0;
        bus.reset_btn_in = 1'b0;

        // Reset values while reset is held.
        edges(3);
        expect_out("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n_in = 1'b1;
        edges(3);

        // Clean set press: s_out low after edges 18 and 19, high at 20.
        bus.set_btn_in = 1'b1;
        edges(18);
        expect_out("set.e17", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(1);
        expect_out("set.e18", 1'b0, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("set.e19", 1'b0, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("set.e20", 1'b1, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("set.e21", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.set_btn_in = 1'b0;
        edges(25);
        expect_out("set.release", 1'b1, 1'b1, 1'b0, 1'b0);

        // Bounce shorter than the debounce window must be ignored.
        glitch = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.set_btn_in = ((i / 5) % 2) == 0;
            edges(1);
            if (bus.s_out !== 1'b1 || bus.r_out !== 1'b1 || bus.busy_out !== 1'b0) glitch = 1'b1;
        end
        bus.set_btn_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            edges(1);
            if (bus.s_out !== 1'b1 || bus.r_out !== 1'b1 || bus.busy_out !== 1'b0) glitch = 1'b1;
        end
        check("bounce.no_pulse", glitch, 1'b0);

        // Simultaneous press: one-cycle conflict, no pulse.
        bus.set_btn_in = 1'b1;
        bus.reset_btn_in = 1'b1;
        edges(18);
        expect_out("both.e17", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(1);
        expect_out("both.e18", 1'b1, 1'b1, 1'b0, 1'b1);
        edges(1);
        expect_out("both.e19", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.set_btn_in = 1'b0;
        bus.reset_btn_in = 1'b0;
        edges(25);
        expect_out("both.after", 1'b1, 1'b1, 1'b0, 1'b0);

        // Queued request: reset pressed 4 cycles after set.
        bus.set_btn_in = 1'b1;
        edges(4);
        bus.reset_btn_in = 1'b1;
        edges(14);
        expect_out("queue.e17", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(1);
        expect_out("queue.e18", 1'b0, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e19", 1'b0, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e20", 1'b1, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e21", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(1);
        expect_out("queue.e22", 1'b1, 1'b0, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e23", 1'b1, 1'b0, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e24", 1'b1, 1'b1, 1'b1, 1'b0);
        edges(1);
        expect_out("queue.e25", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.set_btn_in = 1'b0;
        bus.reset_btn_in = 1'b0;
        edges(25);

        // Reset mid-pulse releases s_out at once; the held button then
        // re-debounces from scratch after reset removal.
        bus.set_btn_in = 1'b1;
        edges(19);
        check("midrst.pulse_low", bus.s_out, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        expect_out("midrst.async", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(2);
        rst_n_in = 1'b1;
        edges(18);
        expect_out("held.e17", 1'b1, 1'b1, 1'b0, 1'b0);
        edges(1);
        expect_out("held.e18", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.set_btn_in = 1'b0;
        edges(25);

        // Random bouncing soak; the negedge watcher checks invariant and widths.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.set_btn_in = !bus.set_btn_in;
            if ($urandom_range(0, 7) == 0) bus.reset_btn_in = !bus.reset_btn_in;
            edges(1);
        end
        bus.set_btn_in = 1'b0;
        bus.reset_btn_in = 1'b0;
        edges(60);
        expect_out("soak.end", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
